// File: rtl/cpu32_pkg.sv
// Shared CPU32 constants: register file geometry, datapath width and the
// writeback requester indices used by regfile_wb_scheduler.
package cpu32_pkg;
    localparam int N_REGS     = 32;
    localparam int REG_ADRS_W = 5;
    localparam int DATA_W     = 32;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LSU    = 1;
    localparam int REQ_MULDIV = 2;
    localparam int N_REQ      = 3;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector
//   ptr   - index of the most recent winner; search starts at ptr+1 and wraps
//   grant - one-hot grant (all zero when nothing requests)
//   idx   - encoded index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int N_REQ = 3,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register file writeback scheduler: round-robin sharing of the single write
// port between writeback requesters, plus a per-register busy scoreboard that
// provides source hazard flags and a WAW issue stall.
// Ports:
//   clk_cpu, reset             - clock, async active-high reset
//   req_valid/req_ready        - per-requester writeback handshake (one-hot grant)
//   req_rd/req_data            - packed destination/data per requester
//   wr_en/wr_adrs/wr_data      - registered register_file write port
//   iss_valid/iss_rd/iss_ready - issue of an instruction writing iss_rd
//   chk_adrs_*/hazard_*        - source registers and their pending-write flags
module regfile_wb_scheduler
    import cpu32_pkg::*;
#(
    parameter int N_REQ_P  = N_REQ,
    parameter int N_REGS_P = N_REGS,
    parameter int DATA_W_P = DATA_W
) (
    input  logic                      clk_cpu,
    input  logic                      reset,
    input  logic [N_REQ_P-1:0]        req_valid,
    output logic [N_REQ_P-1:0]        req_ready,
    input  logic [N_REQ_P*5-1:0]      req_rd,
    input  logic [N_REQ_P*DATA_W_P-1:0] req_data,
    output logic                      wr_en,
    output logic [4:0]                wr_adrs,
    output logic [DATA_W_P-1:0]       wr_data,
    input  logic                      iss_valid,
    input  logic [4:0]                iss_rd,
    output logic                      iss_ready,
    input  logic [4:0]                chk_adrs_a,
    input  logic [4:0]                chk_adrs_b,
    input  logic [4:0]                chk_adrs_c,
    output logic                      hazard_a,
    output logic                      hazard_b,
    output logic                      hazard_c
);

    localparam int IDX_W = (N_REQ_P > 1) ? $clog2(N_REQ_P) : 1;

    logic [4:0]          rd_arr   [N_REQ_P];
    logic [DATA_W_P-1:0] data_arr [N_REQ_P];

    for (genvar i = 0; i < N_REQ_P; i++) begin : g_unpack
        assign rd_arr[i]   = req_rd[5*i +: 5];
        assign data_arr[i] = req_data[DATA_W_P*i +: DATA_W_P];
    end

    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ_P-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                any_grant;

    logic                wr_en_q, wr_en_d;
    logic [4:0]          wr_adrs_q, wr_adrs_d;
    logic [DATA_W_P-1:0] wr_data_q, wr_data_d;
    logic [N_REGS_P-1:0] busy_q, busy_d;

    rr_arbiter #(.N_REQ(N_REQ_P)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // No handshake may complete while reset is held, since the write would be lost.
    assign req_ready = reset ? '0 : arb_grant;
    assign any_grant = |req_ready;

    assign iss_ready = !busy_q[iss_rd];
    assign hazard_a  = busy_q[chk_adrs_a];
    assign hazard_b  = busy_q[chk_adrs_b];
    assign hazard_c  = busy_q[chk_adrs_c];

    assign wr_en   = wr_en_q;
    assign wr_adrs = wr_adrs_q;
    assign wr_data = wr_data_q;

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_adrs_d = wr_adrs_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;

        if (any_grant) begin
            rr_ptr_d  = arb_idx;
            wr_en_d   = (rd_arr[arb_idx] != 5'd0);
            wr_adrs_d = rd_arr[arb_idx];
            wr_data_d = data_arr[arb_idx];
        end

        // Clear at the commit edge; a set in the same cycle can only hit a
        // different register because iss_ready is low while the bit is set.
        if (wr_en_q) busy_d[wr_adrs_q] = 1'b0;
        if (iss_valid && iss_ready && iss_rd != 5'd0) busy_d[iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= IDX_W'(N_REQ_P - 1);
            wr_en_q   <= 1'b0;
            wr_adrs_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_adrs_q <= wr_adrs_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
    logic        clk_cpu = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic        wr_en;
    logic [4:0]  wr_adrs;
    logic [31:0] wr_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [4:0]  chk_adrs_a, chk_adrs_b, chk_adrs_c;
    logic        hazard_a, hazard_b, hazard_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_cpu = ~clk_cpu;

    regfile_wb_scheduler dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .wr_en      (wr_en),
        .wr_adrs    (wr_adrs),
        .wr_data    (wr_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .chk_adrs_a (chk_adrs_a),
        .chk_adrs_b (chk_adrs_b),
        .chk_adrs_c (chk_adrs_c),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .hazard_c   (hazard_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven 1 time unit after it.
    task automatic tick();
        @(posedge clk_cpu);
        #1;
    endtask

    initial begin
        logic [2:0] exp_gnt;
        logic [4:0] exp_rd;

        reset      = 1'b1;
        req_valid  = 3'b111;
        req_rd     = '0;
        req_data   = '0;
        iss_valid  = 1'b0;
        iss_rd     = 5'd0;
        chk_adrs_a = 5'd0;
        chk_adrs_b = 5'd0;
        chk_adrs_c = 5'd0;
        tick(); tick();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        req_valid = 3'b000;
        tick();
        reset = 1'b0;
        #1;
        // idle after reset
        chk("idle_wr_en", 32'(wr_en), 32'h0);
        chk("idle_wr_adrs", 32'(wr_adrs), 32'h0);
        chk("idle_wr_data", wr_data, 32'h0);
        chk("idle_req_ready", 32'(req_ready), 32'h0);
        chk_adrs_a = 5'd5; chk_adrs_b = 5'd31; chk_adrs_c = 5'd1;
        #1;
        chk("idle_haz", 32'({hazard_a, hazard_b, hazard_c}), 32'h0);
        iss_rd = 5'd0;  #1; chk("idle_iss_rdy0", 32'(iss_ready), 32'h1);
        iss_rd = 5'd5;  #1; chk("idle_iss_rdy5", 32'(iss_ready), 32'h1);
        iss_rd = 5'd31; #1; chk("idle_iss_rdy31", 32'(iss_ready), 32'h1);

        // issue rd=5, ALU writes it back
        tick();
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1; chk("iss5_ready", 32'(iss_ready), 32'h1);
        tick();
        iss_valid = 1'b0;
        chk_adrs_a = 5'd5;
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd5}; req_data = {32'h0, 32'h0, 32'h1234_5678};
        #1;
        chk("wb5_haz_before", 32'(hazard_a), 32'h1);
        chk("wb5_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 3'b000;
        #1;
        chk("wb5_wr_en", 32'(wr_en), 32'h1);
        chk("wb5_wr_adrs", 32'(wr_adrs), 32'd5);
        chk("wb5_wr_data", wr_data, 32'h1234_5678);
        chk("wb5_haz_during", 32'(hazard_a), 32'h1);
        tick();
        #1;
        chk("wb5_wr_en_off", 32'(wr_en), 32'h0);
        chk("wb5_wr_adrs_hold", 32'(wr_adrs), 32'd5);
        chk("wb5_haz_after", 32'(hazard_a), 32'h0);

        // MULDIV alone, so the pointer rests on requester 2
        req_valid = 3'b100; req_rd = {5'd4, 5'd0, 5'd0}; req_data = {32'hCAFE_0004, 32'h0, 32'h0};
        #1; chk("md_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 3'b000;
        #1;
        chk("md_wr_adrs", 32'(wr_adrs), 32'd4);
        chk("md_wr_data", wr_data, 32'hCAFE_0004);

        // three-way contention, rd 1/2/3
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
        for (int k = 0; k < 6; k++) begin
            exp_gnt = 3'b001 << (k % 3);
            #1; chk($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(exp_gnt));
            tick();
            exp_rd = 5'((k % 3) + 1);
            chk($sformatf("rr_wr_en_%0d", k), 32'(wr_en), 32'h1);
            chk($sformatf("rr_wr_adrs_%0d", k), 32'(wr_adrs), 32'(exp_rd));
            chk($sformatf("rr_wr_data_%0d", k), wr_data, 32'hAAAA_0000 | 32'(exp_rd));
        end
        req_valid = 3'b000;

        // WAW on rd=7
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1; chk("waw_first_ready", 32'(iss_ready), 32'h1);
        tick();
        #1; chk("waw_stall", 32'(iss_ready), 32'h0);
        iss_rd = 5'd0; chk_adrs_b = 5'd0;
        #1; chk("waw_rd0_ready", 32'(iss_ready), 32'h1);
        tick();
        #1; chk("waw_rd0_haz", 32'(hazard_b), 32'h0);
        iss_rd = 5'd7;
        #1; chk("waw_still_stall", 32'(iss_ready), 32'h0);
        iss_valid = 1'b0;
        req_valid = 3'b010; req_rd = {5'd0, 5'd7, 5'd0}; req_data = {32'h0, 32'h7777_7777, 32'h0};
        #1; chk("waw_lsu_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 3'b000;
        #1;
        chk("waw_wr_adrs", 32'(wr_adrs), 32'd7);
        chk("waw_stall_at_commit", 32'(iss_ready), 32'h0);
        tick();
        #1; chk("waw_released", 32'(iss_ready), 32'h1);

        // LSU writeback to rd=0
        req_valid = 3'b010; req_rd = 15'd0; req_data = {32'h0, 32'hDEAD_BEEF, 32'h0};
        #1; chk("rd0_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 3'b000;
        #1; chk("rd0_wr_en", 32'(wr_en), 32'h0);

        // reset while a write is pending and rd 9 busy
        iss_valid = 1'b1; iss_rd = 5'd9; chk_adrs_c = 5'd9;
        tick();
        iss_valid = 1'b0;
        #1; chk("rst_haz9_set", 32'(hazard_c), 32'h1);
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd10}; req_data = {32'h0, 32'h0, 32'h5555_AAAA};
        tick();
        req_valid = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
        #1; chk("rst_pending_wr_en", 32'(wr_en), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 32'h0);
        chk("rst_mid_wr_adrs", 32'(wr_adrs), 32'h0);
        chk("rst_mid_wr_data", wr_data, 32'h0);
        chk("rst_mid_haz9", 32'(hazard_c), 32'h0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'h0);
        tick();
        reset = 1'b0;
        #1; chk("post_rst_tie", 32'(req_ready), 32'h1);
        tick();
        #1; chk("post_rst_wr_adrs", 32'(wr_adrs), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the register file's single write port between N_REQ writeback requesters (ALU, load/store unit, mul/div) using round-robin arbitration.
- Keeps a per-register busy scoreboard: set when an instruction with a destination register issues, cleared when its writeback commits.
- Gives the decode stage a hazard flag for up to three source addresses, and a WAW stall on issue.
- Sits between the execute units and register_file; drives register_file's wr_en, wr_adrs and wr_data directly.

Parameters:
- N_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = MULDIV).
- N_REGS, 32, number of architectural registers; must match `N_REGS.
- DATA_W, 32, writeback data width.

Ports:
- clk_cpu  in  1  CPU clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i holds a writeback.
- req_ready  out  N_REQ  one-hot grant; the transfer happens when valid and ready are both high.
- req_rd  in  N_REQ*5  destination register of requester i, packed at [5i+4:5i].
- req_data  in  N_REQ*DATA_W  writeback data of requester i.
- wr_en  out  1  register file write enable (registered).
- wr_adrs  out  5  register file write address (registered).
- wr_data  out  DATA_W  register file write data (registered).
- iss_valid  in  1  decode is issuing an instruction that writes iss_rd.
- iss_rd  in  5  destination register of the issuing instruction.
- iss_ready  out  1  issue accepted this cycle (combinational).
- chk_adrs_a, chk_adrs_b, chk_adrs_c  in  5 each  source registers to check.
- hazard_a, hazard_b, hazard_c  out  1 each  the matching source has a pending write (combinational).

Behaviour:
- Reset (asynchronous, active-high):
  - busy cleared to 0.
  - wr_en, wr_adrs and wr_data are 0.
  - rr_ptr = N_REQ-1, so requester 0 has top priority in the first cycle.
  - req_ready is all zero while reset is asserted.
  - A reset mid-operation drops any granted-but-uncommitted write; that write is lost by design.
- Arbitration (combinational):
  - Search starts at index (rr_ptr+1) mod N_REQ and wraps.
  - The first requester with req_valid high is granted; exactly one or zero bits of req_ready are high.
  - req_ready never asserts without req_valid.
  - On a grant to index g, rr_ptr <= g at the next edge; with no grant, rr_ptr holds.
- Write pipeline: grant in cycle T gives wr_en=1 in T+1, with wr_adrs/wr_data = the granted req_rd/req_data sampled at the T edge.
  - If the granted rd is 0, the request is consumed but wr_en stays 0.
  - Without a grant, wr_en=0 and wr_adrs/wr_data hold their previous values.
- Throughput: one writeback per cycle; a requester held valid sees back-to-back grants only when it is the sole valid requester.
- Scoreboard (busy[N_REGS], busy[0] hardwired 0):
  - Set: when iss_valid && iss_ready && iss_rd != 0, busy[iss_rd] <= 1.
  - Clear: when wr_en==1, busy[wr_adrs] <= 0. This is the edge at which register_file commits, so a clear bit implies the data is readable.
  - iss_ready = !busy[iss_rd] (a WAW stall); always 1 for iss_rd==0.
  - Set and clear of the same register in one cycle cannot occur, because iss_ready is low while the bit is set. A set of register X and a clear of register Y in the same cycle both take effect.
- Hazards: hazard_x = busy[chk_adrs_x]; always 0 for address 0. No forwarding from wr_data; decode must stall.
- Latency from grant to a clear hazard for that register: 2 cycles (grant T, write T+1, hazard low in T+2).
- Writeback to a non-busy register (not issued through this block) is still performed; the clear is harmless.

Decomposition:
- Shared package (cpu32_pkg): N_REGS, REG_ADRS_W=5, DATA_W, requester index constants REQ_ALU/REQ_LSU/REQ_MULDIV, N_REQ.
- One natural sub-module: rr_arbiter (parameter N_REQ; inputs req, ptr; outputs one-hot grant and encoded index), combinational and reusable for the memory-port arbiter.
- Scoreboard and write-pipeline registers stay in the top module.

Test Plan:
- Reset then idle: wr_en=0, all hazard_* = 0, iss_ready=1 for every iss_rd, req_ready=000.
- Issue rd=5, then ALU writes rd=5 data 0x1234_5678 one cycle later: hazard_a (chk=5) is high until the cycle after wr_en; wr_en=1, wr_adrs=5, wr_data=0x12345678 one cycle after the grant; hazard low the next cycle.
- All three requesters valid continuously with rd 1/2/3: grant order 0,1,2,0,1,2; wr_adrs sequence 1,2,3,1,2,3 with wr_en high every cycle.
- WAW: issue rd=7, then iss_valid with rd=7 again: iss_ready=0 until the writeback to 7 commits, then 1; issue rd=0 at any time gives iss_ready=1 and busy is unchanged.
- Writeback with rd=0 from LSU: req_ready[1]=1, and wr_en stays 0 the next cycle.
- Assert reset while wr_en is pending and busy[9]=1: outputs go to 0 immediately, hazard for 9 clears, and after release requester 0 wins a three-way tie.
